// File: rtl/mem_access_if.sv
// Data-memory request/response channel between the MEM stage and the memory.
interface mem_access_if #(
    parameter int unsigned WORD_BITWIDTH = 32
) ();
    logic                     dmem_req;
    logic                     dmem_we;
    logic [WORD_BITWIDTH-1:0] dmem_addr;
    logic [WORD_BITWIDTH-1:0] dmem_wdata;
    logic                     dmem_ready;
    logic [WORD_BITWIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: issues data-memory accesses with wait-state stalling,
// timeout and misalignment detection, and drives the MEM/WB register.
module mem_access #(
    parameter int unsigned REG_NUM_BITWIDTH = 5,
    parameter int unsigned WORD_BITWIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_memRead,
    input  logic                        mem_memWrite,
    input  logic [WORD_BITWIDTH-1:0]    mem_ALUresult,
    input  logic [WORD_BITWIDTH-1:0]    mem_regReadData2,
    input  logic                        mem_wt_memToReg,
    input  logic                        mem_wt_regWrite,
    input  logic [REG_NUM_BITWIDTH-1:0] mem_wt_regToWrite,
    input  logic                        flush,
    mem_access_if.master                dmem,
    output logic                        stall,
    output logic                        wb_memToReg,
    output logic                        wb_regWrite,
    output logic [REG_NUM_BITWIDTH-1:0] wb_regToWrite,
    output logic [WORD_BITWIDTH-1:0]    wb_ALUresult,
    output logic [WORD_BITWIDTH-1:0]    wb_memData,
    output logic                        err_misalign,
    output logic                        err_timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, stateNext;
    logic [CNT_W-1:0]  waitCnt;

    logic isAccess, isAligned;
    logic stallRaw, startAcc, completeAcc, timeoutHit, misAlign, cntInc;
    logic wbBubble, wbLoad, wbKill;

    assign isAccess  = mem_memRead | mem_memWrite;
    assign isAligned = (mem_ALUresult[1:0] == 2'b00);

    // Reset forces IDLE immediately, so stall must not follow a held access
    assign stall = stallRaw & ~rst;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (!flush && isAccess && isAligned) stateNext = BUSY;
            BUSY: if (dmem.dmem_ready || (waitCnt == TIMEOUT_LAST)) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Per-state control decode; ready wins over timeout on the last cycle
    always_comb begin
        stallRaw    = 1'b0;
        startAcc    = 1'b0;
        completeAcc = 1'b0;
        timeoutHit  = 1'b0;
        misAlign    = 1'b0;
        cntInc      = 1'b0;
        wbBubble    = 1'b0;
        wbLoad      = 1'b0;
        wbKill      = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    wbBubble = 1'b1;
                end else if (isAccess && isAligned) begin
                    stallRaw = 1'b1;
                    startAcc = 1'b1;
                    wbBubble = 1'b1;
                end else if (isAccess) begin
                    misAlign = 1'b1;
                    wbKill   = 1'b1;
                end else begin
                    wbLoad = 1'b1;
                end
            end
            BUSY: begin
                if (dmem.dmem_ready) begin
                    completeAcc = 1'b1;
                    wbLoad      = 1'b1;
                end else if (waitCnt == TIMEOUT_LAST) begin
                    timeoutHit = 1'b1;
                    wbKill     = 1'b1;
                end else begin
                    stallRaw = 1'b1;
                    cntInc   = 1'b1;
                    wbBubble = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Memory request, wait counter and error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt         <= '0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            err_misalign    <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            if (startAcc) begin
                waitCnt         <= '0;
                dmem.dmem_req   <= 1'b1;
                dmem.dmem_we    <= mem_memWrite;
                dmem.dmem_addr  <= mem_ALUresult;
                dmem.dmem_wdata <= mem_regReadData2;
            end else begin
                if (cntInc) waitCnt <= waitCnt + CNT_W'(1);
                if (completeAcc || timeoutHit) dmem.dmem_req <= 1'b0;
            end
            if (misAlign)   err_misalign <= 1'b1;
            if (timeoutHit) err_timeout  <= 1'b1;
        end
    end

    // MEM/WB register: pass-through, bubble, or retire-without-writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_memToReg   <= 1'b0;
            wb_regWrite   <= 1'b0;
            wb_regToWrite <= '0;
            wb_ALUresult  <= '0;
            wb_memData    <= '0;
        end else begin
            if (wbBubble) begin
                wb_memToReg <= 1'b0;
                wb_regWrite <= 1'b0;
            end
            if (wbLoad) begin
                wb_memToReg   <= mem_wt_memToReg;
                wb_regWrite   <= mem_wt_regWrite;
                wb_regToWrite <= mem_wt_regToWrite;
                wb_ALUresult  <= mem_ALUresult;
            end
            if (wbKill) begin
                wb_memToReg   <= 1'b0;
                wb_regWrite   <= 1'b0;
                wb_regToWrite <= mem_wt_regToWrite;
                wb_ALUresult  <= mem_ALUresult;
            end
            if (completeAcc && !dmem.dmem_we) wb_memData <= dmem.dmem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads, stores, errors, flush, reset.
module tb_mem_access;

    localparam int unsigned RW = 5;
    localparam int unsigned WW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_memRead, mem_memWrite;
    logic [WW-1:0] mem_ALUresult, mem_regReadData2;
    logic          mem_wt_memToReg, mem_wt_regWrite;
    logic [RW-1:0] mem_wt_regToWrite;
    logic          flush;
    logic          stall;
    logic          wb_memToReg, wb_regWrite;
    logic [RW-1:0] wb_regToWrite;
    logic [WW-1:0] wb_ALUresult, wb_memData;
    logic          err_misalign, err_timeout;

    int nPass  = 0;
    int nCheck = 0;

    mem_access_if #(.WORD_BITWIDTH(WW)) dmemBus ();

    mem_access #(
        .REG_NUM_BITWIDTH(RW),
        .WORD_BITWIDTH(WW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_memRead(mem_memRead),
        .mem_memWrite(mem_memWrite),
        .mem_ALUresult(mem_ALUresult),
        .mem_regReadData2(mem_regReadData2),
        .mem_wt_memToReg(mem_wt_memToReg),
        .mem_wt_regWrite(mem_wt_regWrite),
        .mem_wt_regToWrite(mem_wt_regToWrite),
        .flush(flush),
        .dmem(dmemBus.master),
        .stall(stall),
        .wb_memToReg(wb_memToReg),
        .wb_regWrite(wb_regWrite),
        .wb_regToWrite(wb_regToWrite),
        .wb_ALUresult(wb_ALUresult),
        .wb_memData(wb_memData),
        .err_misalign(err_misalign),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCheck++;
        assert (obs === exp) begin
            nPass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idleInputs();
        mem_memRead       = 1'b0;
        mem_memWrite      = 1'b0;
        mem_ALUresult     = '0;
        mem_regReadData2  = '0;
        mem_wt_memToReg   = 1'b0;
        mem_wt_regWrite   = 1'b0;
        mem_wt_regToWrite = '0;
        flush             = 1'b0;
        dmemBus.dmem_ready = 1'b0;
        dmemBus.dmem_rdata = '0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic m2r, input logic rw,
                          input logic [4:0] rd_idx);
        mem_memRead       = rd;
        mem_memWrite      = wr;
        mem_ALUresult     = addr;
        mem_regReadData2  = wdata;
        mem_wt_memToReg   = m2r;
        mem_wt_regWrite   = rw;
        mem_wt_regToWrite = rd_idx;
    endtask

    initial begin
        idleInputs();
        rst = 1'b1;
        #3;
        chk("rst_req",      32'(dmemBus.dmem_req), 32'd0);
        chk("rst_stall",    32'(stall),            32'd0);
        chk("rst_wb_rw",    32'(wb_regWrite),      32'd0);
        chk("rst_wb_mem",   wb_memData,            32'd0);
        chk("rst_err",      32'({err_misalign, err_timeout}), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Non-memory op passes straight through with one-cycle latency
        access(1'b0, 1'b0, 32'h1234, 32'h0, 1'b0, 1'b1, 5'd5);
        #1 chk("alu_stall0", 32'(stall), 32'd0);
        tick();
        chk("alu_wb_rw",  32'(wb_regWrite),   32'd1);
        chk("alu_wb_rd",  32'(wb_regToWrite), 32'd5);
        chk("alu_wb_res", wb_ALUresult,       32'h1234);
        chk("alu_stall1", 32'(stall),         32'd0);
        idleInputs();

        // Zero-wait load
        access(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 5'd7);
        #1 chk("ld_stall_issue", 32'(stall), 32'd1);
        tick();
        dmemBus.dmem_ready = 1'b1;
        dmemBus.dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_req",       32'(dmemBus.dmem_req), 32'd1);
        chk("ld_we",        32'(dmemBus.dmem_we),  32'd0);
        chk("ld_addr",      dmemBus.dmem_addr,     32'h100);
        chk("ld_stall_rdy", 32'(stall),            32'd0);
        chk("ld_bubble",    32'(wb_regWrite),      32'd0);
        tick();
        chk("ld_wb_data", wb_memData,            32'hDEADBEEF);
        chk("ld_wb_rw",   32'(wb_regWrite),      32'd1);
        chk("ld_wb_m2r",  32'(wb_memToReg),      32'd1);
        chk("ld_wb_rd",   32'(wb_regToWrite),    32'd7);
        chk("ld_req_end", 32'(dmemBus.dmem_req), 32'd0);
        idleInputs();
        #1 chk("ld_stall_end", 32'(stall), 32'd0);

        // Store (read also set: write wins) with 3 wait cycles
        access(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 1'b0, 5'd0);
        #1 chk("st_stall_issue", 32'(stall), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("st_wait_stall", 32'(stall),            32'd1);
            chk("st_wait_we",    32'(dmemBus.dmem_we),  32'd1);
            chk("st_wait_addr",  dmemBus.dmem_addr,     32'h40);
            chk("st_wait_wdata", dmemBus.dmem_wdata,    32'hA5A5A5A5);
            tick();
        end
        dmemBus.dmem_ready = 1'b1;
        dmemBus.dmem_rdata = 32'h11111111;
        #1;
        chk("st_rdy_stall", 32'(stall),            32'd0);
        chk("st_rdy_req",   32'(dmemBus.dmem_req), 32'd1);
        chk("st_rdy_addr",  dmemBus.dmem_addr,     32'h40);
        tick();
        chk("st_req_end", 32'(dmemBus.dmem_req), 32'd0);
        chk("st_wb_data", wb_memData,            32'hDEADBEEF);
        idleInputs();

        // Misaligned load
        access(1'b1, 1'b0, 32'h102, 32'h0, 1'b1, 1'b1, 5'd3);
        #1 chk("mis_stall", 32'(stall), 32'd0);
        tick();
        chk("mis_req",    32'(dmemBus.dmem_req), 32'd0);
        chk("mis_err",    32'(err_misalign),     32'd1);
        chk("mis_wb_rw",  32'(wb_regWrite),      32'd0);
        chk("mis_wb_m2r", 32'(wb_memToReg),      32'd0);
        chk("mis_no_to",  32'(err_timeout),      32'd0);
        idleInputs();

        // Timeout with ready held low (TIMEOUT_CYCLES = 4)
        access(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b1, 5'd6);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_req",   32'(dmemBus.dmem_req), 32'd1);
            chk("to_stall", 32'(stall),            (i < 3) ? 32'd1 : 32'd0);
            tick();
        end
        chk("to_req_end", 32'(dmemBus.dmem_req), 32'd0);
        chk("to_err",     32'(err_timeout),      32'd1);
        chk("to_wb_rw",   32'(wb_regWrite),      32'd0);
        chk("to_wb_m2r",  32'(wb_memToReg),      32'd0);
        chk("to_mis_sticky", 32'(err_misalign),  32'd1);
        idleInputs();

        // Flush in IDLE kills the access
        access(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 5'd2);
        flush = 1'b1;
        #1 chk("fl_idle_stall", 32'(stall), 32'd0);
        tick();
        chk("fl_idle_req",   32'(dmemBus.dmem_req), 32'd0);
        chk("fl_idle_wb_rw", 32'(wb_regWrite),      32'd0);
        idleInputs();

        // Flush during BUSY is ignored
        access(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b1, 5'd9);
        tick();
        flush = 1'b1;
        dmemBus.dmem_ready = 1'b1;
        dmemBus.dmem_rdata = 32'hCAFEF00D;
        #1 chk("fl_busy_req", 32'(dmemBus.dmem_req), 32'd1);
        tick();
        chk("fl_busy_data", wb_memData,            32'hCAFEF00D);
        chk("fl_busy_rw",   32'(wb_regWrite),      32'd1);
        chk("fl_busy_rd",   32'(wb_regToWrite),    32'd9);
        chk("fl_busy_end",  32'(dmemBus.dmem_req), 32'd0);
        idleInputs();

        // Reset on BUSY cycle 2 with the access still presented
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd4);
        tick();
        tick();
        chk("rb_req_pre", 32'(dmemBus.dmem_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rb_req",   32'(dmemBus.dmem_req),  32'd0);
        chk("rb_addr",  dmemBus.dmem_addr,      32'd0);
        chk("rb_stall", 32'(stall),             32'd0);
        chk("rb_wb",    32'({wb_regWrite, wb_memToReg, wb_regToWrite}), 32'd0);
        chk("rb_wb_alu", wb_ALUresult,          32'd0);
        chk("rb_wb_mem", wb_memData,            32'd0);
        chk("rb_err",   32'({err_misalign, err_timeout}), 32'd0);
        idleInputs();
        tick();
        rst = 1'b0;

        // Pass-through works again after reset
        access(1'b0, 1'b0, 32'h55AA, 32'h0, 1'b0, 1'b1, 5'd1);
        tick();
        chk("post_wb_res", wb_ALUresult,       32'h55AA);
        chk("post_wb_rw",  32'(wb_regWrite),   32'd1);
        idleInputs();
        tick();

        $display("%0d/%0d checks passed", nPass, nCheck);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters SHALL be: REG_NUM_BITWIDTH, default 5, register-index width; WORD_BITWIDTH, default 32, data and address width; TIMEOUT_CYCLES, default 255, maximum BUSY cycles per access (range 1..255).
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_memRead  in  1  EX/MEM load request.
- mem_memWrite  in  1  EX/MEM store request.
- mem_ALUresult  in  WORD_BITWIDTH  byte address, or ALU result for non-memory ops.
- mem_regReadData2  in  WORD_BITWIDTH  store data.
- mem_wt_memToReg  in  1  WB selects memory data.
- mem_wt_regWrite  in  1  WB register-write enable.
- mem_wt_regToWrite  in  REG_NUM_BITWIDTH  destination register.
- flush  in  1  synchronous bubble insert into MEM/WB.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = write, registered.
- dmem_addr  out  WORD_BITWIDTH  word-aligned address, registered.
- dmem_wdata  out  WORD_BITWIDTH  write data, registered.
- dmem_ready  in  1  memory completes the request this cycle.
- dmem_rdata  in  WORD_BITWIDTH  read data, valid when dmem_ready=1.
- stall  out  1  combinational; upstream EX/MEM SHALL hold while 1.
- wb_memToReg  out  1  registered MEM/WB control.
- wb_regWrite  out  1  registered MEM/WB control.
- wb_regToWrite  out  REG_NUM_BITWIDTH  registered MEM/WB destination register.
- wb_ALUresult  out  WORD_BITWIDTH  registered MEM/WB ALU result.
- wb_memData  out  WORD_BITWIDTH  registered MEM/WB load data.
- err_misalign  out  1  sticky; set by a misaligned access.
- err_timeout  out  1  sticky; set by an access timeout.

Function
REQ-003 The block SHALL use a two-state FSM, IDLE and BUSY; the encoding is implementation choice.
REQ-004 An access is defined as mem_memRead | mem_memWrite; it is aligned when mem_ALUresult[1:0] == 0.
REQ-005 In IDLE, an aligned access with flush=0 SHALL do all of the following:
- assert stall combinationally;
- at the next edge, move to BUSY;
- at the same edge, set dmem_req=1, load dmem_addr=mem_ALUresult, dmem_wdata=mem_regReadData2, dmem_we=mem_memWrite;
- at the same edge, clear the timeout counter.
REQ-006 If mem_memRead and mem_memWrite are both 1, the access SHALL be a write (dmem_we=1), and wb_memData SHALL keep its previous value.
REQ-007 dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL stay constant throughout BUSY.
REQ-008 In BUSY with dmem_ready=1, the block SHALL:
- set stall=0;
- at the next edge, return to IDLE and set dmem_req=0;
- at the same edge, load wb_memData=dmem_rdata (reads only);
- at the same edge, load the other wb_* outputs from the mem_wt_* inputs and mem_ALUresult.
REQ-009 In BUSY with dmem_ready=0, stall SHALL be 1 and the counter SHALL increment.
REQ-010 Timeout: in BUSY, if the counter equals TIMEOUT_CYCLES-1 and dmem_ready=0:
- stall SHALL be 0 that cycle;
- at the next edge, the FSM returns to IDLE with dmem_req=0 and err_timeout=1;
- the instruction retires with wb_regWrite=0 and wb_memToReg=0.
REQ-011 In IDLE, a misaligned access SHALL:
- issue no request and not stall;
- set err_misalign=1 at the next edge;
- retire with wb_regWrite=0 and wb_memToReg=0.
REQ-012 In IDLE with no access, the wb_* outputs SHALL load from the inputs at every edge (1-cycle latency); wb_memData SHALL hold.
REQ-013 While stall=1, each edge SHALL load a bubble: wb_regWrite=0, wb_memToReg=0; the other wb_* outputs hold.
REQ-014 flush=1 in IDLE SHALL load a bubble at the next edge and SHALL NOT start an access or set any error flag.
REQ-015 flush=1 in BUSY SHALL be ignored; the transaction completes normally.
REQ-016 err_misalign and err_timeout SHALL be cleared only by rst.
REQ-017 dmem_ready in IDLE SHALL be ignored.

Reset
REQ-018 rst=1 SHALL immediately force the FSM to IDLE, the counter to 0, and every output register (dmem_*, wb_*, err_*) to 0, including mid-BUSY; the pending transaction is dropped.
REQ-019 After rst is released, the first access SHALL start no earlier than the first rising edge.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Non-memory op: regWrite=1, rd=5, ALUresult=0x1234 -> one edge later wb_regWrite=1, wb_regToWrite=5, wb_ALUresult=0x1234, stall never 1.
- Load with zero wait: read at 0x100, dmem_ready=1 on the first BUSY cycle with rdata=0xDEADBEEF -> stall high for exactly 1 cycle, dmem_addr=0x100, wb_memData=0xDEADBEEF two edges after issue.
- Store with 3 wait cycles: write 0xA5A5A5A5 to 0x40 -> dmem_we=1 and addr/wdata stable for 4 BUSY cycles, stall high for 4 cycles, wb_memData unchanged.
- Misaligned and timeout: read at 0x102 -> no dmem_req, err_misalign=1, wb_regWrite=0; with TIMEOUT_CYCLES=4 and ready held 0 -> dmem_req high for exactly 4 cycles, then err_timeout=1, stall=0.
- Reset during BUSY: rst asserted on BUSY cycle 2 -> dmem_req=0, stall=0, all wb_* and err_* 0 immediately.
- Flush: flush=1 with an aligned read in IDLE -> no request, wb_regWrite=0; flush=1 during BUSY -> transaction still completes and retires.
